// File: rtl/vdp_super_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vdp_super_vram_arbiter
// Description : Slot scheduler for the shared 32-bit super-res VRAM port.
//               Slot 0 of every 4-clock group may be owned by the display
//               fetch; every other slot is shared round-robin between the
//               CPU byte port and the 32-bit command engine. Reads are tagged
//               and their data is returned LATENCY clocks after address issue.
// Revision    : 1.0 - initial release
// ============================================================================
module vdp_super_vram_arbiter #(
  parameter int LATENCY = 3,
  parameter int ADDR_W  = 18
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vdp_super,
  input  logic [9:0]        cx,
  input  logic              display_fetch_active,
  input  logic [ADDR_W-1:0] display_addr,
  output logic [31:0]       vrm_32,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W+1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              cmd_req,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_be,
  output logic              cmd_ack,
  output logic [31:0]       cmd_rdata,
  output logic              cmd_rvalid,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [31:0]       vram_wdata,
  output logic [3:0]        vram_be,
  input  logic [31:0]       vram_rd
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_CMD  = 2'd3
  } owner_t;

  typedef enum logic {
    RR_CPU = 1'b0,
    RR_CMD = 1'b1
  } rr_t;

  typedef struct packed {
    owner_t     owner;
    logic [1:0] lane;
  } tag_t;

  rr_t                   rr_ptr;
  tag_t [LATENCY-1:0]    tag_pipe;
  tag_t                  issue_tag;
  tag_t                  ret_tag;
  logic                  disp_slot;
  logic                  contended;
  logic                  cpu_win;
  logic                  cmd_win;
  logic [ADDR_W-1:0]     next_addr;
  logic                  next_we;
  logic [31:0]           next_wdata;
  logic [3:0]            next_be;

  // Only the slot number (cx[1:0]) matters; the rest of the counter is ignored.
  logic unused_cx;
  assign unused_cx = ^cx[9:2];

  // Slot ownership and round-robin winner selection.
  always_comb begin
    disp_slot = vdp_super && display_fetch_active && (cx[1:0] == 2'd0);
    contended = !disp_slot && cpu_req && cmd_req;
    cpu_win   = !disp_slot && cpu_req && (!cmd_req || (rr_ptr == RR_CPU));
    cmd_win   = !disp_slot && cmd_req && !cpu_win;
  end

  // Grant pulses coincide with the edge that loads the vram_* registers.
  assign cpu_ack = reset_n & cpu_win;
  assign cmd_ack = reset_n & cmd_win;

  // Next VRAM command and the tag that accompanies a read into the pipeline.
  always_comb begin
    next_addr  = vram_addr;
    next_we    = 1'b0;
    next_wdata = vram_wdata;
    next_be    = vram_be;
    issue_tag  = '{owner: OWN_NONE, lane: 2'b00};
    if (disp_slot) begin
      next_addr = display_addr;
      next_be   = 4'hF;
      issue_tag = '{owner: OWN_DISP, lane: 2'b00};
    end else if (cpu_win) begin
      next_addr = cpu_addr[ADDR_W+1:2];
      if (cpu_we) begin
        next_we    = 1'b1;
        next_wdata = {4{cpu_wdata}};
        next_be    = 4'b0001 << cpu_addr[1:0];
      end else begin
        next_be   = 4'hF;
        issue_tag = '{owner: OWN_CPU, lane: cpu_addr[1:0]};
      end
    end else if (cmd_win) begin
      next_addr = cmd_addr;
      if (cmd_we) begin
        // A write with no byte enabled is acknowledged but never strobed.
        next_we    = |cmd_be;
        next_wdata = cmd_wdata;
        next_be    = cmd_be;
      end else begin
        next_be   = 4'hF;
        issue_tag = '{owner: OWN_CMD, lane: 2'b00};
      end
    end
  end

  // Registered VRAM port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vram_addr  <= '0;
      vram_we    <= 1'b0;
      vram_wdata <= '0;
      vram_be    <= '0;
    end else begin
      vram_addr  <= next_addr;
      vram_we    <= next_we;
      vram_wdata <= next_wdata;
      vram_be    <= next_be;
    end
  end

  // Round-robin pointer moves to the loser only when both ports competed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= RR_CPU;
    end else if (contended) begin
      rr_ptr <= cpu_win ? RR_CMD : RR_CPU;
    end
  end

  // Tag shift register; reset discards every in-flight read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= issue_tag;
      for (int s = 1; s < LATENCY; s++) begin
        tag_pipe[s] <= tag_pipe[s-1];
      end
    end
  end

  assign ret_tag = tag_pipe[LATENCY-1];

  // Read-data return, steered by the tag leaving the last pipeline stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vrm_32     <= '0;
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
      cmd_rdata  <= '0;
      cmd_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= (ret_tag.owner == OWN_CPU);
      cmd_rvalid <= (ret_tag.owner == OWN_CMD);
      if (ret_tag.owner == OWN_DISP) begin
        vrm_32 <= vram_rd;
      end
      if (ret_tag.owner == OWN_CPU) begin
        cpu_rdata <= vram_rd[{ret_tag.lane, 3'b000} +: 8];
      end
      if (ret_tag.owner == OWN_CMD) begin
        cmd_rdata <= vram_rd;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vdp_super_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vdp_super_vram_arbiter
// Description : Self-checking bench for vdp_super_vram_arbiter: directed
//               vector table, hand-written display/CPU/reset/contention
//               sequences and a randomized run against a slot-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vdp_super_vram_arbiter;

  localparam int LAT = 3;
  localparam int AW  = 18;

  logic          clk;
  logic          reset_n;
  logic          vdp_super;
  logic [9:0]    cx;
  logic          display_fetch_active;
  logic [AW-1:0] display_addr;
  logic [31:0]   vrm_32;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW+1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_ack;
  logic [7:0]    cpu_rdata;
  logic          cpu_rvalid;
  logic          cmd_req;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic [3:0]    cmd_be;
  logic          cmd_ack;
  logic [31:0]   cmd_rdata;
  logic          cmd_rvalid;
  logic [AW-1:0] vram_addr;
  logic          vram_we;
  logic [31:0]   vram_wdata;
  logic [3:0]    vram_be;
  logic [31:0]   vram_rd;

  int n_cmp = 0;
  int n_err = 0;

  vdp_super_vram_arbiter #(.LATENCY(LAT), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .vdp_super(vdp_super), .cx(cx),
    .display_fetch_active(display_fetch_active), .display_addr(display_addr),
    .vrm_32(vrm_32),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .cmd_req(cmd_req), .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_be(cmd_be), .cmd_ack(cmd_ack), .cmd_rdata(cmd_rdata), .cmd_rvalid(cmd_rvalid),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata),
    .vram_be(vram_be), .vram_rd(vram_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Address-derived memory contents; word 0x00101 holds a known pattern.
  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    if (a == 18'h00101) return 32'hDDCCBBAA;
    return 32'h9E37_79B9 ^ {a[15:0], a[17:2]};
  endfunction

  // Memory: data for an address issued at edge N is sampled at edge N+LAT.
  logic [AW-1:0] rd_d1, rd_d2;
  always @(posedge clk) begin
    rd_d1 <= vram_addr;
    rd_d2 <= rd_d1;
  end
  assign vram_rd = mem_word(rd_d2);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cx = cx + 10'd1;
  endtask

  task automatic idle_inputs();
    vdp_super = 1'b0; display_fetch_active = 1'b0; display_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cmd_req = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_be = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cx = '0;
  endtask

  task automatic check_zero(input string p);
    check({p, "_vrm_32"}, vrm_32, 0);
    check({p, "_cpu_ack"}, {31'd0, cpu_ack}, 0);
    check({p, "_cpu_rdata"}, {24'd0, cpu_rdata}, 0);
    check({p, "_cpu_rvalid"}, {31'd0, cpu_rvalid}, 0);
    check({p, "_cmd_ack"}, {31'd0, cmd_ack}, 0);
    check({p, "_cmd_rdata"}, cmd_rdata, 0);
    check({p, "_cmd_rvalid"}, {31'd0, cmd_rvalid}, 0);
    check({p, "_vram_addr"}, {14'd0, vram_addr}, 0);
    check({p, "_vram_we"}, {31'd0, vram_we}, 0);
    check({p, "_vram_wdata"}, vram_wdata, 0);
    check({p, "_vram_be"}, {28'd0, vram_be}, 0);
  endtask

  typedef struct {
    logic vdp; logic dfa; logic [9:0] cx; logic [AW-1:0] daddr;
    logic creq; logic cwe; logic [AW+1:0] caddr; logic [7:0] cwd;
    logic mreq; logic mwe; logic [AW-1:0] maddr; logic [31:0] mwd; logic [3:0] mbe;
    logic e_cack; logic e_mack; logic [AW-1:0] e_addr; logic e_we;
    logic chk_be; logic [3:0] e_be; logic chk_wd; logic [31:0] e_wd;
  } vec_t;

  vec_t vt [14];

  // Random-phase scoreboard: expected returns indexed by edge number mod 8.
  bit          sc_cpu_v  [8];
  logic [7:0]  sc_cpu_d  [8];
  bit          sc_cmd_v  [8];
  logic [31:0] sc_cmd_d  [8];
  bit          sc_disp_v [8];
  logic [31:0] sc_disp_d [8];

  initial begin
    int            e;
    int            slot;
    bit            cpu_turn;
    bit            free, g_cpu, g_cmd;
    logic [AW-1:0] exp_addr;
    logic [31:0]   exp_vrm;
    logic [31:0]   w;
    logic [3:0]    x_be;
    logic [31:0]   x_wd;
    bit            x_we, x_chk_be, x_chk_wd;
    int            free_cnt, cpu_wait, cmd_wait, max_wait;

    cx = '0;
    reset_n = 1'b0;
    idle_inputs();
    cpu_req = 1'b1;
    cmd_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    do_reset();

    // ---------------- directed vector table ----------------
    vt[0]  = '{1'b1,1'b1,10'd0,18'h00100, 1'b1,1'b0,20'h00404,8'h00, 1'b0,1'b0,18'h0,32'h0,4'h0,
               1'b0,1'b0,18'h00100,1'b0, 1'b1,4'hF, 1'b0,32'h0};
    vt[1]  = '{1'b1,1'b1,10'd1,18'h00100, 1'b1,1'b0,20'h00406,8'h00, 1'b0,1'b0,18'h0,32'h0,4'h0,
               1'b1,1'b0,18'h00101,1'b0, 1'b1,4'hF, 1'b0,32'h0};
    vt[2]  = '{1'b1,1'b1,10'd2,18'h00100, 1'b1,1'b1,20'h00003,8'h5A, 1'b0,1'b0,18'h0,32'h0,4'h0,
               1'b1,1'b0,18'h00000,1'b1, 1'b1,4'h8, 1'b1,32'h5A5A5A5A};
    vt[3]  = '{1'b1,1'b1,10'd3,18'h00100, 1'b0,1'b0,20'h00000,8'h00, 1'b1,1'b1,18'h2ABCD,32'h12345678,4'h5,
               1'b0,1'b1,18'h2ABCD,1'b1, 1'b1,4'h5, 1'b1,32'h12345678};
    vt[4]  = '{1'b1,1'b0,10'd4,18'h00100, 1'b1,1'b0,20'h00010,8'h00, 1'b1,1'b0,18'h00020,32'h0,4'h0,
               1'b1,1'b0,18'h00004,1'b0, 1'b1,4'hF, 1'b0,32'h0};
    vt[5]  = '{1'b1,1'b1,10'd5,18'h00100, 1'b1,1'b0,20'h00010,8'h00, 1'b1,1'b0,18'h00020,32'h0,4'h0,
               1'b0,1'b1,18'h00020,1'b0, 1'b1,4'hF, 1'b0,32'h0};
    vt[6]  = '{1'b1,1'b1,10'd6,18'h00100, 1'b0,1'b0,20'h00000,8'h00, 1'b1,1'b1,18'h00033,32'hCAFEF00D,4'h0,
               1'b0,1'b1,18'h00033,1'b0, 1'b1,4'h0, 1'b0,32'h0};
    vt[7]  = '{1'b0,1'b1,10'd8,18'h00100, 1'b0,1'b0,20'h00000,8'h00, 1'b1,1'b0,18'h00777,32'h0,4'h0,
               1'b0,1'b1,18'h00777,1'b0, 1'b1,4'hF, 1'b0,32'h0};
    vt[8]  = '{1'b1,1'b0,10'd9,18'h00100, 1'b0,1'b0,20'h00000,8'h00, 1'b0,1'b0,18'h0,32'h0,4'h0,
               1'b0,1'b0,18'h00777,1'b0, 1'b0,4'h0, 1'b0,32'h0};
    vt[9]  = '{1'b1,1'b0,10'd12,18'h00100, 1'b1,1'b0,20'h0000C,8'h00, 1'b0,1'b0,18'h0,32'h0,4'h0,
               1'b1,1'b0,18'h00003,1'b0, 1'b1,4'hF, 1'b0,32'h0};
    vt[10] = '{1'b1,1'b1,10'd16,18'h3FFFF, 1'b1,1'b0,20'h00050,8'h00, 1'b1,1'b0,18'h00060,32'h0,4'h0,
               1'b0,1'b0,18'h3FFFF,1'b0, 1'b1,4'hF, 1'b0,32'h0};
    vt[11] = '{1'b1,1'b1,10'd17,18'h3FFFF, 1'b1,1'b1,20'h00001,8'hC3, 1'b1,1'b0,18'h00060,32'h0,4'h0,
               1'b1,1'b0,18'h00000,1'b1, 1'b1,4'h2, 1'b1,32'hC3C3C3C3};
    vt[12] = '{1'b1,1'b1,10'd1023,18'h3FFFF, 1'b1,1'b0,20'h00050,8'h00, 1'b1,1'b0,18'h3FFFF,32'h0,4'h0,
               1'b0,1'b1,18'h3FFFF,1'b0, 1'b1,4'hF, 1'b0,32'h0};
    vt[13] = '{1'b1,1'b1,10'd0,18'h00200, 1'b0,1'b0,20'h00000,8'h00, 1'b1,1'b0,18'h00123,32'h0,4'h0,
               1'b0,1'b0,18'h00200,1'b0, 1'b1,4'hF, 1'b0,32'h0};

    for (int i = 0; i < 14; i++) begin
      vdp_super = vt[i].vdp; display_fetch_active = vt[i].dfa; cx = vt[i].cx;
      display_addr = vt[i].daddr;
      cpu_req = vt[i].creq; cpu_we = vt[i].cwe; cpu_addr = vt[i].caddr; cpu_wdata = vt[i].cwd;
      cmd_req = vt[i].mreq; cmd_we = vt[i].mwe; cmd_addr = vt[i].maddr;
      cmd_wdata = vt[i].mwd; cmd_be = vt[i].mbe;
      @(negedge clk);
      check($sformatf("v%0d_cpu_ack", i), {31'd0, cpu_ack}, {31'd0, vt[i].e_cack});
      check($sformatf("v%0d_cmd_ack", i), {31'd0, cmd_ack}, {31'd0, vt[i].e_mack});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_vram_addr", i), {14'd0, vram_addr}, {14'd0, vt[i].e_addr});
      check($sformatf("v%0d_vram_we", i), {31'd0, vram_we}, {31'd0, vt[i].e_we});
      if (vt[i].chk_be) check($sformatf("v%0d_vram_be", i), {28'd0, vram_be}, {28'd0, vt[i].e_be});
      if (vt[i].chk_wd) check($sformatf("v%0d_vram_wdata", i), vram_wdata, vt[i].e_wd);
    end

    // ---------------- display fetch + CPU read return ----------------
    do_reset();
    vdp_super = 1'b1; display_fetch_active = 1'b1; display_addr = 18'h00100;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00406;
    @(negedge clk);
    check("disp_slot_cpu_ack", {31'd0, cpu_ack}, 0);
    tick();
    check("disp_vram_addr", {14'd0, vram_addr}, 32'h00100);
    check("disp_vram_we", {31'd0, vram_we}, 0);
    display_fetch_active = 1'b0;
    @(negedge clk);
    check("cpurd_ack", {31'd0, cpu_ack}, 1);
    tick();
    cpu_req = 1'b0;
    check("cpurd_vram_addr", {14'd0, vram_addr}, 32'h00101);
    check("cpurd_vram_be", {28'd0, vram_be}, 32'hF);
    tick();
    check("disp_vrm_early", vrm_32, 0);
    check("cpurd_rvalid_e2", {31'd0, cpu_rvalid}, 0);
    tick();
    check("disp_vrm_32", vrm_32, mem_word(18'h00100));
    check("cpurd_rvalid_e3", {31'd0, cpu_rvalid}, 0);
    tick();
    check("cpurd_rvalid", {31'd0, cpu_rvalid}, 1);
    check("cpurd_rdata", {24'd0, cpu_rdata}, 32'hCC);
    tick();
    check("cpurd_rvalid_drop", {31'd0, cpu_rvalid}, 0);
    check("disp_vrm_hold", vrm_32, mem_word(18'h00100));

    // ---------------- randomized run against slot-level model ----------------
    do_reset();
    e = 0; cpu_turn = 1'b1; exp_addr = '0; exp_vrm = '0;
    for (int k = 0; k < 8; k++) begin
      sc_cpu_v[k] = 0; sc_cmd_v[k] = 0; sc_disp_v[k] = 0;
      sc_cpu_d[k] = '0; sc_cmd_d[k] = '0; sc_disp_d[k] = '0;
    end
    vdp_super = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) vdp_super = !vdp_super;
      display_fetch_active = ($urandom_range(0, 1) == 1);
      display_addr = 18'($urandom);
      if (!cpu_req || $urandom_range(0, 19) == 0) begin
        cpu_req = ($urandom_range(0, 2) != 0);
        cpu_we = ($urandom_range(0, 1) == 1);
        cpu_addr = 20'($urandom);
        cpu_wdata = 8'($urandom);
      end
      if (!cmd_req || $urandom_range(0, 19) == 0) begin
        cmd_req = ($urandom_range(0, 2) != 0);
        cmd_we = ($urandom_range(0, 1) == 1);
        cmd_addr = 18'($urandom);
        cmd_wdata = $urandom;
        cmd_be = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      end
      @(negedge clk);
      free = !(vdp_super && display_fetch_active && (cx[1:0] == 2'd0));
      g_cpu = 0; g_cmd = 0;
      if (free) begin
        if (cpu_req && cmd_req) begin
          if (cpu_turn) g_cpu = 1; else g_cmd = 1;
          cpu_turn = !cpu_turn;
        end else begin
          g_cpu = cpu_req;
          g_cmd = cmd_req;
        end
      end
      check("rnd_cpu_ack", {31'd0, cpu_ack}, {31'd0, g_cpu});
      check("rnd_cmd_ack", {31'd0, cmd_ack}, {31'd0, g_cmd});
      slot = (e + 1 + LAT) % 8;
      x_we = 0; x_chk_be = 0; x_chk_wd = 0; x_be = '0; x_wd = '0;
      if (!free) begin
        exp_addr = display_addr; x_chk_be = 1; x_be = 4'hF;
        sc_disp_v[slot] = 1; sc_disp_d[slot] = mem_word(display_addr);
      end else if (g_cpu) begin
        exp_addr = cpu_addr[AW+1:2];
        if (cpu_we) begin
          x_we = 1; x_chk_be = 1; x_chk_wd = 1;
          x_be = 4'(1 << cpu_addr[1:0]);
          x_wd = {4{cpu_wdata}};
        end else begin
          x_chk_be = 1; x_be = 4'hF;
          w = mem_word(cpu_addr[AW+1:2]);
          sc_cpu_v[slot] = 1; sc_cpu_d[slot] = w[8*int'(cpu_addr[1:0]) +: 8];
        end
      end else if (g_cmd) begin
        exp_addr = cmd_addr;
        if (cmd_we) begin
          x_we = (cmd_be != 4'h0); x_chk_be = 1; x_be = cmd_be;
          x_chk_wd = x_we; x_wd = cmd_wdata;
        end else begin
          x_chk_be = 1; x_be = 4'hF;
          sc_cmd_v[slot] = 1; sc_cmd_d[slot] = mem_word(cmd_addr);
        end
      end
      tick();
      e++;
      check("rnd_vram_addr", {14'd0, vram_addr}, {14'd0, exp_addr});
      check("rnd_vram_we", {31'd0, vram_we}, {31'd0, x_we});
      if (x_chk_be) check("rnd_vram_be", {28'd0, vram_be}, {28'd0, x_be});
      if (x_chk_wd) check("rnd_vram_wdata", vram_wdata, x_wd);
      slot = e % 8;
      check("rnd_cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, sc_cpu_v[slot]});
      if (sc_cpu_v[slot]) check("rnd_cpu_rdata", {24'd0, cpu_rdata}, {24'd0, sc_cpu_d[slot]});
      check("rnd_cmd_rvalid", {31'd0, cmd_rvalid}, {31'd0, sc_cmd_v[slot]});
      if (sc_cmd_v[slot]) check("rnd_cmd_rdata", cmd_rdata, sc_cmd_d[slot]);
      if (sc_disp_v[slot]) exp_vrm = sc_disp_d[slot];
      check("rnd_vrm_32", vrm_32, exp_vrm);
      sc_cpu_v[slot] = 0; sc_cmd_v[slot] = 0; sc_disp_v[slot] = 0;
      if (g_cpu) cpu_req = 1'b0;
      if (g_cmd) cmd_req = 1'b0;
    end

    // ---------------- reset during an in-flight CPU read ----------------
    vdp_super = 1'b0; display_fetch_active = 1'b0;
    cmd_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00406;
    @(negedge clk);
    check("rstmid_cpu_ack", {31'd0, cpu_ack}, 1);
    tick();
    cpu_req = 1'b0;
    tick();
    reset_n = 1'b0;
    cpu_req = 1'b1; cmd_req = 1'b1; cmd_we = 1'b1; cmd_be = 4'hF;
    @(negedge clk);
    check_zero("rstmid");
    tick();
    reset_n = 1'b1;
    cpu_req = 1'b0; cmd_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("rstmid_no_rvalid%0d", k), {31'd0, cpu_rvalid}, 0);
      tick();
    end

    // ---------------- sustained contention, display slots interleaved ----------------
    vdp_super = 1'b1; display_fetch_active = 1'b1; display_addr = 18'h00055;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00100;
    cmd_req = 1'b1; cmd_we = 1'b0; cmd_addr = 18'h00200;
    free_cnt = 0; cpu_wait = 0; cmd_wait = 0; max_wait = 0;
    for (int k = 0; k < 40 && free_cnt < 12; k++) begin
      @(negedge clk);
      if (cx[1:0] == 2'd0) begin
        check("cont_disp_cpu_ack", {31'd0, cpu_ack}, 0);
        check("cont_disp_cmd_ack", {31'd0, cmd_ack}, 0);
      end else begin
        check($sformatf("cont%0d_cpu_ack", free_cnt), {31'd0, cpu_ack}, {31'd0, (free_cnt % 2) == 0});
        check($sformatf("cont%0d_cmd_ack", free_cnt), {31'd0, cmd_ack}, {31'd0, (free_cnt % 2) == 1});
        cpu_wait = cpu_ack ? 0 : cpu_wait + 1;
        cmd_wait = cmd_ack ? 0 : cmd_wait + 1;
        if (cpu_wait > max_wait) max_wait = cpu_wait;
        if (cmd_wait > max_wait) max_wait = cmd_wait;
        free_cnt++;
      end
      tick();
    end
    check("cont_free_slots", free_cnt, 12);
    check("cont_max_wait_ok", {31'd0, max_wait <= 2}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vdp_super_vram_arbiter.md
Name: vdp_super_vram_arbiter

Overview:
- Slot scheduler for the shared 32-bit VRAM port used in super-res mode.
- Arbitrates per pixel clock between three requesters: the super-res display fetch (fixed-slot, highest priority), the CPU port (byte access) and the command engine (32-bit access with byte enables).
- Tags every issued access, returns read data after the fixed memory latency, and owns vram_addr / vram_we / vram_wdata / vram_be.

Parameters:
- LATENCY, 3, clocks from address issue to valid vram_rd (range 1..4).
- ADDR_W, 18, VRAM word-address width.

Ports:
- clk  in  1  pixel/system clock
- reset_n  in  1  asynchronous active-low reset
- vdp_super  in  1  super-res mode enable
- cx  in  10  horizontal pixel counter
- display_fetch_active  in  1  display owns slot 0 this cycle
- display_addr  in  ADDR_W  display fetch address
- vrm_32  out  32  display data, captured from vram_rd
- cpu_req  in  1  CPU request, held until ack
- cpu_we  in  1  1 = write
- cpu_addr  in  ADDR_W+2  byte address
- cpu_wdata  in  8  write byte
- cpu_ack  out  1  one-cycle grant pulse
- cpu_rdata  out  8  read byte
- cpu_rvalid  out  1  one-cycle read-data strobe
- cmd_req  in  1  command engine request, held until ack
- cmd_we  in  1  1 = write
- cmd_addr  in  ADDR_W  word address
- cmd_wdata  in  32  write data
- cmd_be  in  4  byte enables
- cmd_ack  out  1  grant pulse
- cmd_rdata  out  32  read data
- cmd_rvalid  out  1  read-data strobe
- vram_addr  out  ADDR_W  VRAM address (registered)
- vram_we  out  1  VRAM write strobe (registered)
- vram_wdata  out  32  VRAM write data
- vram_be  out  4  VRAM byte enables
- vram_rd  in  32  VRAM read data

Behaviour:
Reset and mode
- While reset_n is low, every output is 0, the tag pipeline is cleared and rr_ptr = CPU.
- Reset asserted mid-access: in-flight reads are discarded; no rvalid is issued after release.

Slot ownership (slot = cx[1:0])
- Slot 0 with vdp_super=1 and display_fetch_active=1: display owns the slot.
  - Drive vram_addr <= display_addr, vram_we <= 0, tag = DISP.
  - No ack is issued to any other requester that cycle.
- Any other cycle is a free slot.
  - Exactly one of cpu/cmd is granted when its req is high.
  - If both are requesting, the one named by rr_ptr wins; rr_ptr then toggles to the loser.
  - A single requester wins regardless of rr_ptr; rr_ptr is unchanged.
- vdp_super=0: every slot is free; display_fetch_active is ignored.

Grant cycle
- The ack pulses in the same cycle that the registered vram_* outputs are loaded; the requester drops or changes its request on the next cycle.
- CPU write:
  - vram_addr = cpu_addr[ADDR_W+1:2]
  - vram_wdata = {4{cpu_wdata}}
  - vram_be = one-hot of cpu_addr[1:0]
  - vram_we = 1
- CMD write: passes cmd_addr, cmd_wdata and cmd_be through; vram_we = 1.
- Write with cmd_be = 0: ack is still issued; vram_we = 0.
- Reads: vram_we = 0 and vram_be = 4'hF.
- No grant in a free slot: vram_we = 0; vram_addr holds its previous value.

Read return
- Tag pipeline is LATENCY stages deep; each stage holds {owner[1:0], lane[1:0]}.
- LATENCY clocks after issue:
  - DISP tag: vrm_32 <= vram_rd.
  - CPU tag: cpu_rdata <= byte lane of vram_rd; cpu_rvalid = 1 for one cycle.
  - CMD tag: cmd_rdata <= vram_rd; cmd_rvalid = 1 for one cycle.
- vrm_32 holds its value between DISP returns.
- Writes carry no tag and produce no rvalid.

Boundaries
- A request withdrawn before ack produces no access.
- Back-to-back grants to the same requester are allowed in consecutive free slots.
- Worst-case wait for a contended request: 2 free slots.
- cx wrap 1023→0 needs no special handling.

Test Plan:
- vdp_super=1, display_fetch_active=1, display_addr=0x00100, LATENCY=3, vram model returns addr-derived data → vram_addr=0x00100 at cx≡0; vrm_32 updates at cx≡3; cpu_ack never high at cx≡0.
- CPU read cpu_addr=0x00406 (word 0x00101, lane 2), memory word 0xDDCCBBAA → cpu_ack once; 3 clocks later cpu_rvalid=1, cpu_rdata=0xCC.
- CPU write cpu_addr=0x00003, cpu_wdata=0x5A → vram_we=1, vram_be=4'b1000, vram_wdata=0x5A5A5A5A.
- cpu_req and cmd_req held high continuously for 12 free slots → grants alternate CPU, CMD, CPU…; no requester waits more than 2 free slots.
- vdp_super=0 with display_fetch_active=1 and cmd_req high at cx=4 → cmd_ack at cx=4; display address never driven.
- CPU read granted, then reset_n pulsed low 1 clock later → all outputs 0 during reset; no cpu_rvalid afterwards; rr_ptr = CPU.
